simd_perm_out_serializer: RTL and testbench



---
 rtl/simd_perm_pkg.sv | 25 ++
 rtl/simd_vec_pingpong.sv | 61 ++++++
 rtl/simd_perm_out_serializer.sv | 91 +++++++++
 tb/tb_simd_perm_out_serializer.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_perm_pkg.sv
// Shared types and sizing for the SIMD permutation datapath: lane/vector types,
// beat geometry for the output serializer, and the ping-pong occupancy encoding.
package simd_perm_pkg;

    localparam int DATA_WIDTH     = 64;
    localparam int NUM_LANES      = 32;
    localparam int LANES_PER_BEAT = 8;
    localparam int BEATS          = NUM_LANES / LANES_PER_BEAT;
    localparam int BEAT_IDX_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BEAT_WIDTH     = LANES_PER_BEAT * DATA_WIDTH;
    localparam int VEC_WIDTH      = NUM_LANES * DATA_WIDTH;

    typedef logic [DATA_WIDTH-1:0] lane_t;
    typedef lane_t [NUM_LANES-1:0] vec_t;

    // Same bits as vec_t, regrouped so that element b is beat b of the vector.
    typedef logic [BEATS-1:0][BEAT_WIDTH-1:0] beat_vec_t;

    typedef enum logic [1:0] {
        SLOTS_EMPTY = 2'd0,
        SLOTS_ONE   = 2'd1,
        SLOTS_FULL  = 2'd2
    } slot_cnt_e;

endpackage

// File: rtl/simd_vec_pingpong.sv
// Two-slot vector buffer: write/read pointers and an occupancy count.
// push_ready_o depends only on registered occupancy, never on pop_i.
module simd_vec_pingpong
    import simd_perm_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push_valid_i,
    output logic                 push_ready_o,
    input  logic [VEC_WIDTH-1:0] push_data_i,
    input  logic                 pop_i,
    output logic                 pop_valid_o,
    output logic [VEC_WIDTH-1:0] pop_data_o
);

    slot_cnt_e cnt_q, cnt_d;
    logic      wr_ptr_q, wr_ptr_d;
    logic      rd_ptr_q, rd_ptr_d;
    vec_t      slot_q [2];
    logic      push;
    logic      pop;

    assign push_ready_o = (cnt_q != SLOTS_FULL);
    assign pop_valid_o  = (cnt_q != SLOTS_EMPTY);
    assign push         = push_valid_i && push_ready_o;
    assign pop          = pop_i && pop_valid_o;
    assign pop_data_o   = slot_q[rd_ptr_q];

    // NOTE: every variable gets its default before any branch, so no path can infer a latch.
    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        case ({push, pop})
            2'b10:   cnt_d = (cnt_q == SLOTS_EMPTY) ? SLOTS_ONE : SLOTS_FULL;
            2'b01:   cnt_d = (cnt_q == SLOTS_FULL) ? SLOTS_ONE : SLOTS_EMPTY;
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q    <= SLOTS_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: slot storage has no reset; cnt_q alone decides whether a slot holds live data.
    always_ff @(posedge clock) begin
        if (push) begin
            slot_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/simd_perm_out_serializer.sv
// Buffers permuted vectors in a ping-pong pair and drains each as BEATS beats.
// Optional saturating stall counter on io_stall_cnt when SIMD_PERM_SER_STALL_CNT_EN is defined.
module simd_perm_out_serializer
    import simd_perm_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_vec_valid,
    output logic                  io_vec_ready,
    input  logic [VEC_WIDTH-1:0]  io_vec_data,
    output logic                  io_out_valid,
    input  logic                  io_out_ready,
    output logic [BEAT_WIDTH-1:0] io_out_data,
    output logic [BEAT_IDX_W-1:0] io_out_beat,
    output logic                  io_out_last
`ifdef SIMD_PERM_SER_STALL_CNT_EN
    ,
    output logic [31:0]           io_stall_cnt
`endif
);

    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

    logic [BEAT_IDX_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [VEC_WIDTH-1:0]  rd_vec;
    beat_vec_t             rd_beats;
    logic                  beat_fire;
    logic                  vec_done;

    simd_vec_pingpong u_pingpong (
        .clock        (clock),
        .reset        (reset),
        .push_valid_i (io_vec_valid),
        .push_ready_o (io_vec_ready),
        .push_data_i  (io_vec_data),
        .pop_i        (vec_done),
        .pop_valid_o  (io_out_valid),
        .pop_data_o   (rd_vec)
    );

    assign beat_fire   = io_out_valid && io_out_ready;
    assign io_out_last = io_out_valid && (beat_cnt_q == LAST_BEAT);
    assign vec_done    = beat_fire && io_out_last;
    assign io_out_beat = beat_cnt_q;

    // The lane select only moves on a handshake, so a stalled beat stays put
    // even when the other slot is being written.
    assign rd_beats    = rd_vec;
    assign io_out_data = rd_beats[beat_cnt_q];

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (vec_done) begin
            beat_cnt_d = '0;
        end else if (beat_fire) begin
            beat_cnt_d = beat_cnt_q + BEAT_IDX_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef SIMD_PERM_SER_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (io_out_valid && !io_out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign io_stall_cnt = stall_cnt_q;
`else
    // No stall statistics in this build.
`endif

endmodule

// File: tb/tb_simd_perm_out_serializer.sv
// Self-checking bench for simd_perm_out_serializer: a queue-of-vectors reference
// model predicts every output each cycle; define SIMD_PERM_SER_STALL_CNT_EN to cover the stall counter.
`timescale 1ns/1ps
module tb_simd_perm_out_serializer;
    import simd_perm_pkg::*;

    typedef struct packed {
        logic                  vec_ready;
        logic                  out_valid;
        logic [BEAT_IDX_W-1:0] beat;
        logic                  last;
        logic [BEAT_WIDTH-1:0] data;
    } snap_t;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  io_vec_valid = 1'b0;
    logic                  io_out_ready = 1'b0;
    logic [VEC_WIDTH-1:0]  io_vec_data = '0;
    logic                  io_vec_ready;
    logic                  io_out_valid;
    logic                  io_out_last;
    logic [BEAT_WIDTH-1:0] io_out_data;
    logic [BEAT_IDX_W-1:0] io_out_beat;
`ifdef SIMD_PERM_SER_STALL_CNT_EN
    logic [31:0]           io_stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: vectors held by the block, oldest first, and the beat being shown.
    vec_t mq[$];
    int   mbeat = 0;

    simd_perm_out_serializer dut (
        .clock        (clock),
        .reset        (reset),
        .io_vec_valid (io_vec_valid),
        .io_vec_ready (io_vec_ready),
        .io_vec_data  (io_vec_data),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_data  (io_out_data),
        .io_out_beat  (io_out_beat),
        .io_out_last  (io_out_last)
`ifdef SIMD_PERM_SER_STALL_CNT_EN
        ,
        .io_stall_cnt (io_stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [BEAT_WIDTH-1:0] beat_of(vec_t v, int b);
        logic [BEAT_WIDTH-1:0] r;
        for (int j = 0; j < LANES_PER_BEAT; j++) begin
            r[j*DATA_WIDTH +: DATA_WIDTH] = v[b*LANES_PER_BEAT + j];
        end
        return r;
    endfunction

    function automatic vec_t seq_vec(lane_t base);
        vec_t v;
        for (int k = 0; k < NUM_LANES; k++) v[k] = base + lane_t'(k);
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int k = 0; k < NUM_LANES; k++) v[k] = {$urandom, $urandom};
        return v;
    endfunction

    function automatic snap_t predicted();
        snap_t s = '0;
        s.vec_ready = (mq.size() < 2);
        s.out_valid = (mq.size() > 0);
        if (s.out_valid) begin
            s.beat = BEAT_IDX_W'(mbeat);
            s.last = (mbeat == BEATS - 1);
            s.data = beat_of(mq[0], mbeat);
        end
        return s;
    endfunction

    function automatic snap_t observed();
        snap_t s;
        s.vec_ready = io_vec_ready;
        s.out_valid = io_out_valid;
        s.beat      = io_out_beat;
        s.last      = io_out_last;
        s.data      = io_out_valid ? io_out_data : '0;
        return s;
    endfunction

    // Advance one clock, updating the model from the handshakes seen before the edge.
    task automatic tick();
        bit   rst_now;
        bit   pop;
        bit   push;
        vec_t pushed;
        rst_now = reset;
        pop     = (mq.size() > 0) && io_out_ready;
        push    = io_vec_valid && (mq.size() < 2);
        pushed  = io_vec_data;
        @(posedge clock);
        if (rst_now) begin
            mq.delete();
            mbeat = 0;
        end else begin
            if (pop) begin
                mbeat++;
                if (mbeat == BEATS) begin
                    void'(mq.pop_front());
                    mbeat = 0;
                end
            end
            if (push) mq.push_back(pushed);
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        io_vec_valid = 1'b0;
        io_out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (io_out_valid !== 1'b0 || io_out_beat !== '0 || io_out_last !== 1'b0 || io_vec_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b beat=%0d last=%b vec_ready=%b, want 0 0 0 1",
                     io_out_valid, io_out_beat, io_out_last, io_vec_ready);
        end
    endtask

    task automatic test_single_vector();
        logic [BEAT_WIDTH-1:0] want;
        snap_t exp, obs;
        io_out_ready = 1'b1;
        io_vec_data  = seq_vec(64'h1000);
        io_vec_valid = 1'b1;
        tick();
        io_vec_valid = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            for (int j = 0; j < LANES_PER_BEAT; j++) begin
                want[j*DATA_WIDTH +: DATA_WIDTH] = 64'h1000 + 64'(LANES_PER_BEAT*b + j);
            end
            n_checks++;
            if (io_out_valid !== 1'b1 || io_out_beat !== BEAT_IDX_W'(b) ||
                io_out_last !== (b == BEATS - 1) || io_out_data !== want) begin
                n_fail++;
                $display("FAIL single_beat%0d: valid=%b beat=%0d last=%b data=%h, want beat %0d data=%h",
                         b, io_out_valid, io_out_beat, io_out_last, io_out_data, b, want);
            end
            exp = predicted();
            obs = observed();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL single_model%0d: got %h want %h", b, obs, exp);
            end
            tick();
        end
        n_checks++;
        if (io_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: valid=%b want 0", io_out_valid);
        end
    endtask

    task automatic test_back_to_back();
        vec_t v [3];
        bit   want_ready;
        for (int i = 0; i < 3; i++) v[i] = rand_vec();
        io_out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            io_vec_data  = v[i];
            io_vec_valid = 1'b1;
            n_checks++;
            if (io_vec_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_accept%0d: vec_ready=%b want 1", i, io_vec_ready);
            end
            tick();
        end
        io_vec_data = v[2];
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (io_vec_ready !== 1'b0 || io_out_valid !== 1'b1 || io_out_beat !== '0 ||
                io_out_data !== beat_of(v[0], 0)) begin
                n_fail++;
                $display("FAIL b2b_full%0d: vec_ready=%b valid=%b beat=%0d, want 0 1 0", c,
                         io_vec_ready, io_out_valid, io_out_beat);
            end
            tick();
        end
        io_out_ready = 1'b1;
        for (int i = 0; i < 3*BEATS; i++) begin
            want_ready = (i == BEATS) || (i >= 2*BEATS);
            n_checks++;
            if (io_out_valid !== 1'b1 || io_out_beat !== BEAT_IDX_W'(i % BEATS) ||
                io_out_data !== beat_of(v[i / BEATS], i % BEATS) || io_vec_ready !== want_ready) begin
                n_fail++;
                $display("FAIL b2b_stream%0d: valid=%b beat=%0d vec_ready=%b data=%h, want beat %0d ready %b data=%h",
                         i, io_out_valid, io_out_beat, io_vec_ready, io_out_data, i % BEATS, want_ready,
                         beat_of(v[i / BEATS], i % BEATS));
            end
            tick();
            if (i == BEATS) io_vec_valid = 1'b0;
        end
        n_checks++;
        if (io_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: valid=%b want 0", io_out_valid);
        end
    endtask

    task automatic test_simultaneous();
        vec_t a, b;
        snap_t exp, obs;
        a = rand_vec();
        b = rand_vec();
        io_out_ready = 1'b1;
        io_vec_data  = a;
        io_vec_valid = 1'b1;
        tick();
        io_vec_valid = 1'b0;
        for (int k = 0; k < BEATS; k++) begin
            if (k == BEATS - 1) begin
                io_vec_data  = b;
                io_vec_valid = 1'b1;
                n_checks++;
                if (io_vec_ready !== 1'b1 || io_out_last !== 1'b1) begin
                    n_fail++;
                    $display("FAIL simul_overlap: vec_ready=%b last=%b want 1 1", io_vec_ready, io_out_last);
                end
            end
            tick();
        end
        io_vec_valid = 1'b0;
        n_checks++;
        if (io_out_valid !== 1'b1 || io_out_beat !== '0 || io_out_data !== beat_of(b, 0) || io_vec_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_next: valid=%b beat=%0d vec_ready=%b data=%h want 1 0 1 %h",
                     io_out_valid, io_out_beat, io_vec_ready, io_out_data, beat_of(b, 0));
        end
        for (int k = 0; k < BEATS; k++) begin
            exp = predicted();
            obs = observed();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL simul_drain%0d: got %h want %h", k, obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_random();
        lane_t sent[$];
        lane_t got[$];
        vec_t  v;
        snap_t exp, obs, prev;
        bit    prev_stall;
        bit    accepted;
        int    nsent;
        int    cycles;
        int    bad;
        prev_stall   = 1'b0;
        prev         = '0;
        nsent        = 0;
        cycles       = 0;
        io_vec_valid = 1'b0;
        while ((nsent < 100 || mq.size() > 0 || io_vec_valid) && cycles < 5000) begin
            if (!io_vec_valid && nsent < 100 && $urandom_range(0, 2) != 0) begin
                io_vec_data  = rand_vec();
                io_vec_valid = 1'b1;
            end
            io_out_ready = ($urandom_range(0, 2) != 0);
            if (io_out_last && $urandom_range(0, 1) == 0) io_out_ready = 1'b0;
            exp = predicted();
            obs = observed();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL rand_model c%0d: got %h want %h", cycles, obs, exp);
            end
            if (prev_stall) begin
                n_checks++;
                if ({obs.out_valid, obs.beat, obs.last, obs.data} !== {prev.out_valid, prev.beat, prev.last, prev.data}) begin
                    n_fail++;
                    $display("FAIL rand_stall_hold c%0d: beat=%0d last=%b, held beat=%0d last=%b",
                             cycles, obs.beat, obs.last, prev.beat, prev.last);
                end
            end
            prev_stall = io_out_valid && !io_out_ready;
            prev       = obs;
            accepted   = io_vec_valid && io_vec_ready;
            if (accepted) begin
                v = io_vec_data;
                for (int k = 0; k < NUM_LANES; k++) sent.push_back(v[k]);
                nsent++;
            end
            if (io_out_valid && io_out_ready) begin
                for (int j = 0; j < LANES_PER_BEAT; j++) got.push_back(io_out_data[j*DATA_WIDTH +: DATA_WIDTH]);
            end
            tick();
            cycles++;
            if (accepted) io_vec_valid = 1'b0;
        end
        n_checks++;
        if (cycles >= 5000) begin
            n_fail++;
            $display("FAIL rand_timeout: %0d vectors sent after %0d cycles", nsent, cycles);
        end
        bad = 0;
        if (got.size() == sent.size()) begin
            foreach (sent[i]) if (got[i] !== sent[i]) bad++;
        end
        n_checks++;
        if (got.size() != sent.size() || bad != 0) begin
            n_fail++;
            $display("FAIL rand_scoreboard: got %0d lanes (%0d differ), want %0d lanes",
                     got.size(), bad, sent.size());
        end
    endtask

    task automatic test_reset_mid_drain();
        vec_t c;
        snap_t exp, obs;
        io_out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            io_vec_data  = rand_vec();
            io_vec_valid = 1'b1;
            tick();
        end
        io_vec_valid = 1'b0;
        io_out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (io_out_valid !== 1'b0 || io_vec_ready !== 1'b1 || io_out_beat !== '0 || io_out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_state: valid=%b vec_ready=%b beat=%0d last=%b want 0 1 0 0",
                     io_out_valid, io_vec_ready, io_out_beat, io_out_last);
        end
        c = rand_vec();
        io_vec_data  = c;
        io_vec_valid = 1'b1;
        tick();
        io_vec_valid = 1'b0;
        n_checks++;
        if (io_out_valid !== 1'b1 || io_out_beat !== '0 || io_out_data !== beat_of(c, 0)) begin
            n_fail++;
            $display("FAIL rstmid_restart: valid=%b beat=%0d data=%h want 1 0 %h",
                     io_out_valid, io_out_beat, io_out_data, beat_of(c, 0));
        end
        for (int k = 0; k < BEATS; k++) begin
            exp = predicted();
            obs = observed();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL rstmid_drain%0d: got %h want %h", k, obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_stall_cnt();
`ifdef SIMD_PERM_SER_STALL_CNT_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (io_stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL stall_reset: cnt=%0d want 0", io_stall_cnt);
        end
        io_out_ready = 1'b0;
        io_vec_data  = rand_vec();
        io_vec_valid = 1'b1;
        tick();
        io_vec_valid = 1'b0;
        repeat (7) tick();
        n_checks++;
        if (io_stall_cnt !== 32'd7) begin
            n_fail++;
            $display("FAIL stall_count: cnt=%0d want 7", io_stall_cnt);
        end
        io_out_ready = 1'b1;
        repeat (BEATS + 1) tick();
        n_checks++;
        if (io_stall_cnt !== 32'd7 || io_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold: cnt=%0d valid=%b want 7 0", io_stall_cnt, io_out_valid);
        end
`else
        $display("stall counter not built; skipping its checks");
`endif
    endtask

    initial begin
        test_reset();
        test_single_vector();
        test_back_to_back();
        test_simultaneous();
        test_random();
        test_reset_mid_drain();
        test_stall_cnt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
